vote_tally_counter: RTL and testbench

Parametrised multi-channel vote tally for the EVM datapath. Extends the single 4-bit enable counter to `NUM_CAND` independent saturating candidate counters plus a running total. A ballot-control state machine accepts exactly one vote per ballot enable. A registered readback port serves the result/display logic.

---
 rtl/vote_tally_if.sv | 30 +++
 rtl/vote_tally_counter.sv | 92 +++++++++
 tb/tb_vote_tally_counter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vote_tally_if.sv
// vote_tally_if: ballot/vote handshake and readback bundle for vote_tally_counter.
// _i/_o suffixes are named from the tally counter's point of view.
interface vote_tally_if #(
    parameter int NUM_CAND = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = CNT_W + SEL_W
);
    logic                clear_i;
    logic                ballot_en_i;
    logic                vote_valid_i;
    logic [SEL_W-1:0]    vote_sel_i;
    logic                vote_ack_o;
    logic                vote_err_o;
    logic                armed_o;
    logic [SEL_W-1:0]    rd_sel_i;
    logic [CNT_W-1:0]    rd_count_o;
    logic [TOT_W-1:0]    total_o;
    logic [NUM_CAND-1:0] sat_o;

    modport master (
        output clear_i, ballot_en_i, vote_valid_i, vote_sel_i, rd_sel_i,
        input  vote_ack_o, vote_err_o, armed_o, rd_count_o, total_o, sat_o
    );

    modport slave (
        input  clear_i, ballot_en_i, vote_valid_i, vote_sel_i, rd_sel_i,
        output vote_ack_o, vote_err_o, armed_o, rd_count_o, total_o, sat_o
    );
endinterface

// File: rtl/vote_tally_counter.sv
// vote_tally_counter: per-candidate saturating vote tallies with a one-vote-per-ballot FSM.
// Every output is a register, so the lamps and readback never glitch.
module vote_tally_counter #(
    parameter int NUM_CAND = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = CNT_W + SEL_W
) (
    input logic         clk,
    input logic         reset,
    vote_tally_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, CAST, WAIT_REL} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q [NUM_CAND];
    logic [CNT_W-1:0]    count_d [NUM_CAND];
    logic [TOT_W-1:0]    total_q, total_d;
    logic [NUM_CAND-1:0] sat_q, sat_d;
    logic [CNT_W-1:0]    rd_count_q;
    logic                ack_q, err_q, err_d, armed_q;
    logic                sel_ok, rd_ok;

    assign sel_ok = 32'(bus.vote_sel_i) < NUM_CAND;
    assign rd_ok  = 32'(bus.rd_sel_i) < NUM_CAND;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        total_d = total_q;
        sat_d   = sat_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_i) begin
                    count_d = '{default: '0};
                    total_d = '0;
                    sat_d   = '0;
                end
                if (bus.ballot_en_i) state_d = ARMED;
            end
            ARMED: begin
                if (bus.vote_valid_i && sel_ok) begin
                    state_d = CAST;
                    // A saturated channel still acknowledges but leaves the total untouched.
                    if (&count_q[bus.vote_sel_i]) begin
                        sat_d[bus.vote_sel_i] = 1'b1;
                    end else begin
                        count_d[bus.vote_sel_i] = count_q[bus.vote_sel_i] + CNT_W'(1);
                        total_d = total_q + TOT_W'(1);
                    end
                end else if (bus.vote_valid_i) begin
                    err_d = 1'b1;
                end else if (!bus.ballot_en_i) begin
                    state_d = IDLE;
                end
            end
            CAST:     state_d = WAIT_REL;
            WAIT_REL: if (!bus.ballot_en_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '{default: '0};
            total_q    <= '0;
            sat_q      <= '0;
            rd_count_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            total_q    <= total_d;
            sat_q      <= sat_d;
            rd_count_q <= rd_ok ? count_q[bus.rd_sel_i] : '0;
            ack_q      <= state_d == CAST;
            err_q      <= err_d;
            armed_q    <= state_d == ARMED;
        end
    end

    assign bus.vote_ack_o = ack_q;
    assign bus.vote_err_o = err_q;
    assign bus.armed_o    = armed_q;
    assign bus.rd_count_o = rd_count_q;
    assign bus.total_o    = total_q;
    assign bus.sat_o      = sat_q;
endmodule

// File: tb/tb_vote_tally_counter.sv
// tb_vote_tally_counter: directed checks of ballot FSM, tallies, saturation, clear and reset.
module tb_vote_tally_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   ack_cnt = 0;

    vote_tally_if #(.NUM_CAND(3), .SEL_W(2), .CNT_W(4), .TOT_W(6)) bus ();

    vote_tally_counter #(.NUM_CAND(3), .SEL_W(2), .CNT_W(4), .TOT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.vote_ack_o) ack_cnt++;
    endtask

    task automatic cast_vote(input logic [1:0] sel);
        bus.ballot_en_i = 1'b1;
        tick();
        bus.vote_valid_i = 1'b1;
        bus.vote_sel_i = sel;
        tick();
        bus.vote_valid_i = 1'b0;
        bus.ballot_en_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        bus.clear_i = 1'b0;
        bus.ballot_en_i = 1'b0;
        bus.vote_valid_i = 1'b0;
        bus.vote_sel_i = '0;
        bus.rd_sel_i = '0;
        tick();
        tick();
        chk("rst_armed", bus.armed_o, 0);
        chk("rst_ack", bus.vote_ack_o, 0);
        chk("rst_err", bus.vote_err_o, 0);
        chk("rst_total", bus.total_o, 0);
        chk("rst_sat", bus.sat_o, 0);
        chk("rst_rd", bus.rd_count_o, 0);
        reset = 1'b0;
        tick();

        // single vote for channel 2
        bus.ballot_en_i = 1'b1;
        tick();
        chk("t1_armed", bus.armed_o, 1);
        bus.vote_valid_i = 1'b1;
        bus.vote_sel_i = 2'd2;
        bus.rd_sel_i = 2'd2;
        tick();
        chk("t1_ack", bus.vote_ack_o, 1);
        chk("t1_total", bus.total_o, 1);
        chk("t1_rd_pre", bus.rd_count_o, 0);
        bus.vote_valid_i = 1'b0;
        tick();
        chk("t1_ack_once", bus.vote_ack_o, 0);
        chk("t1_rd_post", bus.rd_count_o, 1);
        chk("t1_unarmed", bus.armed_o, 0);
        bus.ballot_en_i = 1'b0;
        tick();

        // three presses on one held ballot count once
        ack_cnt = 0;
        bus.ballot_en_i = 1'b1;
        tick();
        bus.vote_sel_i = 2'd1;
        bus.rd_sel_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            bus.vote_valid_i = 1'b1;
            tick();
            bus.vote_valid_i = 1'b0;
            tick();
        end
        chk("t2_acks", ack_cnt, 1);
        chk("t2_total", bus.total_o, 2);
        chk("t2_rd", bus.rd_count_o, 1);
        chk("t2_wait_armed", bus.armed_o, 0);
        bus.ballot_en_i = 1'b0;
        tick();

        // out-of-range press, then a valid one
        bus.ballot_en_i = 1'b1;
        tick();
        bus.vote_valid_i = 1'b1;
        bus.vote_sel_i = 2'd3;
        tick();
        chk("t3_err", bus.vote_err_o, 1);
        chk("t3_armed", bus.armed_o, 1);
        chk("t3_total", bus.total_o, 2);
        bus.vote_valid_i = 1'b0;
        tick();
        chk("t3_err_once", bus.vote_err_o, 0);
        bus.vote_valid_i = 1'b1;
        bus.vote_sel_i = 2'd0;
        tick();
        chk("t3_ack", bus.vote_ack_o, 1);
        chk("t3_total2", bus.total_o, 3);
        bus.vote_valid_i = 1'b0;
        bus.ballot_en_i = 1'b0;
        tick();
        tick();

        // withdrawn ballot
        bus.ballot_en_i = 1'b1;
        tick();
        bus.ballot_en_i = 1'b0;
        tick();
        chk("wd_armed", bus.armed_o, 0);
        chk("wd_total", bus.total_o, 3);

        // clear ignored outside IDLE, honoured in IDLE
        bus.ballot_en_i = 1'b1;
        tick();
        bus.vote_valid_i = 1'b1;
        bus.vote_sel_i = 2'd0;
        tick();
        bus.vote_valid_i = 1'b0;
        bus.clear_i = 1'b1;
        tick();
        tick();
        chk("clr_ignored", bus.total_o, 4);
        bus.clear_i = 1'b0;
        bus.ballot_en_i = 1'b0;
        tick();
        bus.clear_i = 1'b1;
        bus.rd_sel_i = 2'd2;
        tick();
        bus.clear_i = 1'b0;
        chk("clr_total", bus.total_o, 0);
        tick();
        chk("clr_rd2", bus.rd_count_o, 0);

        // saturation of channel 0 at 15
        ack_cnt = 0;
        bus.rd_sel_i = 2'd0;
        for (int i = 0; i < 16; i++) begin
            cast_vote(2'd0);
            if (i == 14) begin
                chk("sat_pre_flag", bus.sat_o, 0);
                chk("sat_pre_total", bus.total_o, 15);
            end
        end
        chk("sat_acks", ack_cnt, 16);
        chk("sat_total", bus.total_o, 15);
        chk("sat_flag", bus.sat_o, 3'b001);
        chk("sat_rd", bus.rd_count_o, 15);

        // clear and ballot together in IDLE
        bus.clear_i = 1'b1;
        bus.ballot_en_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        chk("clrb_armed", bus.armed_o, 1);
        chk("clrb_sat", bus.sat_o, 0);
        chk("clrb_total", bus.total_o, 0);

        // reset during CAST
        bus.vote_valid_i = 1'b1;
        bus.vote_sel_i = 2'd1;
        bus.rd_sel_i = 2'd1;
        tick();
        chk("rc_ack_before", bus.vote_ack_o, 1);
        chk("rc_total_before", bus.total_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("rc_ack", bus.vote_ack_o, 0);
        chk("rc_total", bus.total_o, 0);
        chk("rc_armed", bus.armed_o, 0);
        bus.vote_valid_i = 1'b0;
        bus.ballot_en_i = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("rc_rd", bus.rd_count_o, 0);
        chk("rc_acks", ack_cnt, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
